mem_port_arbiter: RTL

- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage.
- Arbitrates between the two requesters, sequences each access against a fixed-latency memory, and returns read data with a one-cycle ready pulse.
- Drives per-port stall signals back to the pipeline.
- Sits between the pipeline top and the memory model.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline and memory signal bundle for the shared memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              stall_if;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [BE_W-1:0]   dm_be;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              stall_mem;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    output if_rdata, if_ready, stall_if, dm_rdata, dm_ready, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    input  if_rdata, if_ready, stall_if, dm_rdata, dm_ready, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency single-port memory between fetch and data ports
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last_dm;
  logic       gnt_dm;
  logic       grant_if, grant_dm;

  // On a conflict the port that did not go last wins; last_dm resets to fetch so data wins first.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state == IDLE) begin
      if (bus.if_req && bus.dm_req) begin
        grant_dm = ~last_dm;
        grant_if = last_dm;
      end else begin
        grant_if = bus.if_req;
        grant_dm = bus.dm_req;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_if || grant_dm) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Memory strobe and operands are registered at grant so mem_en is high exactly in ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      last_dm       <= 1'b0;
      gnt_dm        <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
      bus.if_ready  <= 1'b0;
      bus.dm_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if || grant_dm) begin
            gnt_dm        <= grant_dm;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= grant_dm && bus.dm_we;
            bus.mem_addr  <= (grant_dm ? bus.dm_addr : bus.if_addr) & ~ADDR_W'(3);
            bus.mem_wdata <= grant_dm ? bus.dm_wdata : DATA_W'(0);
            bus.mem_be    <= (grant_dm && bus.dm_we) ? bus.dm_be : '1;
          end
        end
        ISSUE: begin
          bus.mem_en <= 1'b0;
          cnt        <= LAT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (!bus.mem_we) begin
              if (gnt_dm) bus.dm_rdata <= bus.mem_rdata;
              else        bus.if_rdata <= bus.mem_rdata;
            end
            if (gnt_dm) bus.dm_ready <= 1'b1;
            else        bus.if_ready <= 1'b1;
          end
        end
        RESP: begin
          bus.if_ready <= 1'b0;
          bus.dm_ready <= 1'b0;
          last_dm      <= gnt_dm;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_if  = bus.if_req & ~bus.if_ready;
  assign bus.stall_mem = bus.dm_req & ~bus.dm_ready;
endmodule
